// File: rtl/hc161_counter_pkg.sv
// Shared constants for the HC161-style presettable up/down counter.
// Direction encoding matches the UD pin: 1 counts up, 0 counts down.
package hc161_counter_pkg;

   localparam int   HC_MAX_WIDTH = 16;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage : hc161_counter_pkg

// File: rtl/hc161_counter_tc_decode.sv
// Terminal-count decode: flags the top and bottom of the modulo-N range,
// and whether Q sits above the range, and forms TC (gated by CET, not CEP).
module hc_tc_decode
   import hc161_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_ud,
   input  logic             i_cet,
   output logic             o_tc,
   output logic             o_at_max,
   output logic             o_at_zero,
   output logic             o_over_max
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

   logic w_terminal;

   assign o_at_max  = (i_q == LP_MAX);
   assign o_at_zero = (i_q == '0);

   // A full binary modulus leaves no codes above the range.
   generate
      if (MODULUS == (2 ** WIDTH)) begin : g_full_range
         assign o_over_max = 1'b0;
      end else begin : g_partial_range
         assign o_over_max = (i_q > LP_MAX);
      end
   endgenerate

   assign w_terminal = (i_ud == DIR_UP) ? o_at_max : o_at_zero;
   assign o_tc       = i_cet & w_terminal;

endmodule : hc_tc_decode

// File: rtl/hc161_counter.sv
// Presettable synchronous up/down modulo-N counter (74HC161/191 flavour).
// Load beats count beats hold; RCO pulses for one cycle on each real wrap.
module hc161_counter
   import hc161_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             Clk,
   input  logic             RD,
   input  logic [WIDTH-1:0] D,
   input  logic             PE_n,
   input  logic             CEP,
   input  logic             CET,
   input  logic             UD,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             RCO
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_q;
   logic             r_rco;

   logic [WIDTH-1:0] w_q_next;
   logic             w_rco_next;
   logic             w_tc;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_over_max;

   hc_tc_decode #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tc_decode (
      .i_q        (r_q),
      .i_ud       (UD),
      .i_cet      (CET),
      .o_tc       (w_tc),
      .o_at_max   (w_at_max),
      .o_at_zero  (w_at_zero),
      .o_over_max (w_over_max)
   );

   // Out-of-range values (from a verbatim load) fold back on the next step.
   always_comb begin
      w_q_next   = r_q;
      w_rco_next = 1'b0;
      if (!PE_n) begin
         w_q_next = D;
      end else if (CEP && CET) begin
         w_rco_next = w_tc;
         if (UD == DIR_UP) begin
            w_q_next = (w_at_max || w_over_max) ? '0 : r_q + 1'b1;
         end else begin
            w_q_next = (w_at_zero || w_over_max) ? LP_MAX : r_q - 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge RD) begin
      if (!RD) begin
         r_q   <= '0;
         r_rco <= 1'b0;
      end else begin
         r_q   <= w_q_next;
         r_rco <= w_rco_next;
      end
   end

   assign Q   = r_q;
   assign TC  = w_tc;
   assign RCO = r_rco;

endmodule : hc161_counter

// File: doc/hc161_counter.md
Name: hc161_counter

Overview:
- Presettable synchronous up/down modulo-N binary counter, 74HC161/191 flavour.
- Sits directly upstream of the HC112 dual JK flip-flop and drives its J/K pins from Q bits, for example J = Q[1:0] and K = Q[3:2] at WIDTH=4.
- Sweeps all J/K combinations at a programmable rate, in place of a hand-written stimulus sequence.
- TC/RCO support cascading several instances into wider counters.

Parameters:
- WIDTH, 4: counter width in bits; legal range is 2 to 16.
- MODULUS, 16: count length. States run 0..MODULUS-1. Legal range is 2..2^WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- RD  input  1  reset; asynchronous, active-low.
- D  input  WIDTH  parallel preset data.
- PE_n  input  1  synchronous parallel load enable, active-low.
- CEP  input  1  count enable, parallel.
- CET  input  1  count enable, trickle; also gates TC.
- UD  input  1  direction: 1 = up, 0 = down.
- Q  output  WIDTH  registered count.
- TC  output  1  terminal count, combinational.
- RCO  output  1  ripple carry out, registered, one-cycle pulse.

Behaviour:
- Reset (RD=0): Q=0 and RCO=0 immediately, without waiting for Clk. While RD=0, all other inputs are ignored.
- Release of RD is synchronous in effect: the first possible state change is on the first rising Clk edge with RD=1.
- Priority at each rising edge, highest first:
  1. Load: if PE_n=0, then Q<=D. Load ignores CEP, CET and UD.
  2. Count: if PE_n=1, CEP=1 and CET=1, count one step in the direction given by UD.
  3. Hold: otherwise Q is unchanged.
- Up count: Q<=Q+1. If Q>=MODULUS-1, Q<=0. This covers wrap-around and out-of-range preloads.
- Down count: Q<=Q-1. If Q==0 or Q>MODULUS-1, Q<=MODULUS-1.
- Out-of-range D is loaded verbatim. No error output; the next count step recovers as defined above.
- TC = CET & (UD ? (Q==MODULUS-1) : (Q==0)).
  - TC is combinational from Q, CET and UD, with no Clk dependency.
  - CEP does not gate TC, so cascades follow 74HC161 convention: TC of stage n drives CET of stage n+1.
- RCO is set to 1 for exactly one cycle, on the edge where the counter actually wraps (count step taken while TC=1); otherwise RCO<=0.
  - RCO is 0 after a load, even if D equals the terminal value.
- UD may change on any cycle. The new direction takes effect on the next edge; no pipeline.
- Latency: load and count both take one edge from input to Q.
- MODULUS = 2^WIDTH: wrap reduces to natural binary overflow, with identical behaviour.

Decomposition:
- Shared package:
  - a constant for max WIDTH (16);
  - a direction constant pair, DIR_UP=1 and DIR_DN=0.
- One sub-module is natural: hc_tc_decode. It is combinational, takes Q, UD, CET and MODULUS, and produces TC plus internal at_max and at_zero flags.
- Top level holds:
  - the count register;
  - the next-state priority mux;
  - the RCO register.
- A top-level wrapper, hc161_hc112_pair, instantiates this counter and HC112 with Q mapped to J/K. It is used for system bench integration.

Test Plan:
- Async reset: counter running at Q=7; drop RD between clock edges → Q=0 and RCO=0 within the same time step; Q stays 0 while RD=0.
- Up wrap (WIDTH=4, MODULUS=10): CEP=CET=UD=1 from Q=0 → Q steps 0..9, then 0. TC=1 only while Q=9. RCO=1 for the single cycle after the 9→0 edge.
- Down wrap (MODULUS=10, UD=0): from Q=0 → Q=9, 8, ...; TC=1 while Q=0 and CET=1. Drop CET at Q=0 → TC=0 and Q holds.
- Load priority: PE_n=0, D=4'hC, CEP=CET=1 → Q=12 on next edge. Then count up → Q=0 with no RCO. Count down from 12 → Q=9.
- Enable gating: CEP=0, CET=1 at Q=9 (up) → Q holds at 9, TC stays 1, RCO stays 0.
- Cascade: two instances (WIDTH=4, MODULUS=16), TC of the low stage driving CET of the high stage → combined 8-bit count goes 0x0F→0x10 and 0xFF→0x00. The high-stage RCO pulses once per 256 cycles.
